fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 tb/tb_fetch_unit.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Single-outstanding instruction fetch FSM (REQ/WAIT/VALID/FAULT)
//             with a retired-instruction counter. Optional misaligned-PC trap
//             is enabled by defining MISALIGN_TRAP_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_next,
   input  logic        instr_ready,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic [31:0] fetch_count,
   output logic        fetch_fault
);

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_FAULT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] count_q, count_d;

`ifdef MISALIGN_TRAP_EN
   logic        fault_q, fault_d;
`else
   logic        unused_pc_lsbs;
   assign unused_pc_lsbs = ^pc_next[1:0];
`endif

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      count_d = count_q;
`ifdef MISALIGN_TRAP_EN
      fault_d = fault_q;
`endif
      unique case (state_q)
         S_REQ: begin
            if (imem_gnt) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = S_VALID;
            end
         end
         S_VALID: begin
            if (instr_ready) begin
               // Counter is free-running modulo 2^32; wrap has no side effects.
               count_d = count_q + 32'd1;
`ifdef MISALIGN_TRAP_EN
               pc_d = pc_next;
               if (pc_next[1:0] != 2'b00) begin
                  fault_d = 1'b1;
                  state_d = S_FAULT;
               end else begin
                  state_d = S_REQ;
               end
`else
               pc_d    = {pc_next[31:2], 2'b00};
               state_d = S_REQ;
`endif
            end
         end
         S_FAULT: begin
            state_d = S_FAULT;
         end
         default: begin
            state_d = S_REQ;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_REQ;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         count_q <= 32'd0;
`ifdef MISALIGN_TRAP_EN
         fault_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         count_q <= count_d;
`ifdef MISALIGN_TRAP_EN
         fault_q <= fault_d;
`endif
      end
   end

   assign imem_req    = (state_q == S_REQ);
   assign instr_valid = (state_q == S_VALID);
   assign imem_addr   = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign fetch_count = count_q;
`ifdef MISALIGN_TRAP_EN
   assign fetch_fault = fault_q;
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_unit.sv
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Directed self-checking bench for fetch_unit with a transaction
//             level reference model compared every cycle.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc_next = 32'd0;
   logic        instr_ready = 1'b0;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic [31:0] fetch_count;
   logic        fetch_fault;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .pc_next     (pc_next),
      .instr_ready (instr_ready),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_gnt    (imem_gnt),
      .imem_rvalid (imem_rvalid),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .fetch_count (fetch_count),
      .fetch_fault (fetch_fault)
   );

   always #5 clk = ~clk;

   // Reference model: one request in flight at a time; a fetched word is
   // held until the consumer takes it, then the next PC is fetched.
   logic [31:0] m_pc = 32'd0, m_instr = 32'h13, m_cnt = 32'd0;
   bit          m_inflight = 0, m_holding = 0, m_fault = 0;

   always @(posedge clk) begin
      if (rst) begin
         m_pc = 32'd0; m_instr = 32'h13; m_cnt = 32'd0;
         m_inflight = 0; m_holding = 0; m_fault = 0;
      end else if (m_fault) begin
         // stuck until reset
      end else if (m_holding) begin
         if (instr_ready) begin
            m_cnt = m_cnt + 32'd1;
            m_holding = 0;
`ifdef MISALIGN_TRAP_EN
            m_pc = pc_next;
            if (pc_next % 4 != 0) m_fault = 1;
`else
            m_pc = pc_next - (pc_next % 4);
`endif
         end
      end else if (m_inflight) begin
         if (imem_rvalid) begin
            m_instr = imem_rdata;
            m_inflight = 0;
            m_holding = 1;
         end
      end else if (imem_gnt) begin
         m_inflight = 1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_imem_req",    {31'd0, imem_req},    {31'd0, !m_inflight && !m_holding && !m_fault});
         chk("m_imem_addr",   imem_addr,            m_pc);
         chk("m_pc",          pc,                   m_pc);
         chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, m_holding});
         chk("m_instr",       instr,                m_instr);
         chk("m_fetch_count", fetch_count,          m_cnt);
         chk("m_fetch_fault", {31'd0, fetch_fault}, {31'd0, m_fault});
      end
   end

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic drive(input bit g, input bit rv, input logic [31:0] rd,
                        input bit rdy, input logic [31:0] pn);
      imem_gnt = g; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy; pc_next = pn;
   endtask

   initial begin
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0);
      tick(2);
      rst = 1'b0;
      chk_en = 1'b1;
      chk("rst_req",   {31'd0, imem_req},    32'd1);
      chk("rst_addr",  imem_addr,            32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", instr,                32'h0000_0013);
      chk("rst_count", fetch_count,          32'd0);

      // Minimum latency: grant, then rvalid, then valid.
      drive(1, 0, 0, 0, 0);
      tick();
      chk("wait_req", {31'd0, imem_req}, 32'd0);
      drive(0, 1, 32'h0050_0093, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("lat_valid", {31'd0, instr_valid}, 32'd1);
      chk("lat_instr", instr, 32'h0050_0093);
      chk("lat_pc",    pc,    32'h0);

      // Backpressure for five cycles, then accept.
      drive(0, 1, 32'hBAD0_0001, 0, 32'h8);
      tick(5);
      chk("hold_instr", instr, 32'h0050_0093);
      chk("hold_req",   {31'd0, imem_req}, 32'd0);
      drive(0, 0, 0, 1, 32'h8);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("acc_req",   {31'd0, imem_req}, 32'd1);
      chk("acc_addr",  imem_addr,   32'h8);
      chk("acc_count", fetch_count, 32'd1);

      // No grant for three cycles; rvalid in REQ is ignored.
      drive(0, 1, 32'hDEAD_BEEF, 0, 0);
      tick(3);
      chk("nogrant_req",   {31'd0, imem_req}, 32'd1);
      chk("nogrant_addr",  imem_addr, 32'h8);
      chk("nogrant_instr", instr,     32'h0050_0093);
      drive(1, 1, 32'hBAD0_0002, 0, 0);
      tick();
      chk("gnt_rv_valid", {31'd0, instr_valid}, 32'd0);
      chk("gnt_rv_instr", instr, 32'h0050_0093);
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 1, 32'h0000_0011, 0, 0);
      tick();
      chk("second_instr", instr, 32'h0000_0011);
      chk("second_pc",    pc,    32'h8);

      // Misaligned next PC.
      drive(0, 0, 0, 1, 32'h102);
      tick();
      drive(1, 0, 0, 0, 0);
`ifdef MISALIGN_TRAP_EN
      chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
      chk("mis_pc",    pc,          32'h102);
      chk("mis_count", fetch_count, 32'd2);
      tick(3);
      chk("mis_req_held", {31'd0, imem_req}, 32'd0);
`else
      chk("mis_addr",  imem_addr,   32'h100);
      chk("mis_fault", {31'd0, fetch_fault}, 32'd0);
      tick(3);
`endif

      // Reset while a response arrives in WAIT.
      drive(0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive(1, 0, 0, 0, 0);
      tick();
      rst = 1'b1;
      drive(1, 1, 32'hBAD0_0003, 1, 32'h40);
      tick();
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
      chk("rstwait_req",   {31'd0, imem_req}, 32'd1);
      chk("rstwait_pc",    pc,          32'h0);
      chk("rstwait_valid", {31'd0, instr_valid}, 32'd0);
      chk("rstwait_count", fetch_count, 32'd0);
      chk("rstwait_instr", instr,       32'h0000_0013);

      // Counter wrap: preload all-ones while holding, then accept.
      drive(1, 0, 0, 0, 0);
      tick();
      drive(0, 1, 32'h0000_0033, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      force dut.count_q = 32'hFFFF_FFFF;
      m_cnt = 32'hFFFF_FFFF;
      tick();
      release dut.count_q;
      tick();
      chk("wrap_pre", fetch_count, 32'hFFFF_FFFF);
      drive(0, 0, 0, 1, 32'h20);
      tick();
      drive(1, 0, 0, 0, 0);
      chk("wrap_count", fetch_count, 32'd0);
      chk("wrap_addr",  imem_addr,   32'h20);
      tick();
      drive(0, 1, 32'h0000_0077, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0);
      chk("wrap_cont_valid", {31'd0, instr_valid}, 32'd1);
      chk("wrap_cont_instr", instr, 32'h0000_0077);
      tick(2);

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
